hid_rx_fifo: RTL and testbench

Parametrised multi-channel receive-FIFO bank for the HID subsystem. It takes scan-code strobes from NCH input devices, such as PS/2 keyboard and mouse, and queues each channel in its own DEPTH-entry FIFO. The FIFOs are exposed on the 64-bit hid bus with per-channel status, flush, sticky overflow and a level interrupt. It replaces the single fixed-depth keyboard FIFO: depth, channel count and code width are now generic, and overflow is reported instead of silently lost.

---
 rtl/hid_rx_fifo_if.sv | 25 ++
 rtl/hid_rx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_hid_rx_fifo.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/hid_rx_fifo_if.sv
// HID register bus between a host and the receive-FIFO bank.
// Every access is a single-cycle strobe. Read data is registered by the slave.
interface hid_rx_fifo_if;
    logic        hid_en;
    logic [7:0]  hid_we;
    logic [19:0] hid_addr;
    logic [63:0] hid_wrdata;
    logic [63:0] hid_rddata;

    modport master (
        output hid_en,
        output hid_we,
        output hid_addr,
        output hid_wrdata,
        input  hid_rddata
    );

    modport slave (
        input  hid_en,
        input  hid_we,
        input  hid_addr,
        input  hid_wrdata,
        output hid_rddata
    );
endinterface

// File: rtl/hid_rx_fifo.sv
// Multi-channel scan-code receive FIFO bank with per-channel status, flush,
// sticky overflow and a level interrupt, exposed on the 64-bit HID bus.
module hid_rx_fifo #(
    parameter int NCH    = 2,
    parameter int DEPTH  = 16,
    parameter int CODE_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst,
    input  logic [NCH-1:0]          scan_ready_i,
    input  logic [NCH*CODE_W-1:0]   scan_code_i,
    input  logic [NCH-1:0]          scan_released_i,
    hid_rx_fifo_if.slave            bus,
    output logic                    irq_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = CODE_W + 1;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    logic [NCH-1:0]         rdy_q;
    logic [NCH-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [NCH-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NCH-1:0][CW-1:0] count_q,  count_d;
    logic [NCH-1:0]         ovf_q,    ovf_d;
    logic [NCH-1:0]         ie_q,     ie_d;
    logic [63:0]            rddata_q, rddata_d;
    logic                   irq_q,    irq_d;

    logic [EW-1:0]          mem_q [NCH][DEPTH];

    logic [NCH-1:0]         push_s, pop_s, flush_s, ovf_clr_s, ovf_set_s;
    logic [NCH-1:0]         ctrl_wr_s, mem_we_s, empty_s, full_s, sel_s;
    logic [NCH-1:0][EW-1:0] entry_s, head_s;

    logic                   bus_wr_s, bus_rd_s;
    logic [1:0]             reg_sel_s;
    logic [2:0]             ch_sel_s;
    logic                   unused_bits_s;

    assign bus_wr_s  = bus.hid_en & (|bus.hid_we);
    assign bus_rd_s  = bus.hid_en & ~(|bus.hid_we);
    assign reg_sel_s = bus.hid_addr[4:3];
    assign ch_sel_s  = bus.hid_addr[7:5];

    assign unused_bits_s = ^{bus.hid_addr[19:8], bus.hid_addr[2:0], bus.hid_wrdata[63:3]};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign sel_s[c]     = (ch_sel_s == 3'(c));
        assign push_s[c]    = scan_ready_i[c] & ~rdy_q[c];
        assign entry_s[c]   = {scan_released_i[c], scan_code_i[c*CODE_W +: CODE_W]};
        assign empty_s[c]   = (count_q[c] == CW'(0));
        assign full_s[c]    = (count_q[c] == CW'(DEPTH));
        assign head_s[c]    = mem_q[c][rd_ptr_q[c]];
        assign pop_s[c]     = bus_wr_s & sel_s[c] & (reg_sel_s == REG_DATA) & ~empty_s[c];
        assign ctrl_wr_s[c] = bus_wr_s & sel_s[c] & (reg_sel_s == REG_CTRL);
        assign flush_s[c]   = ctrl_wr_s[c] & bus.hid_wrdata[1];
        assign ovf_clr_s[c] = ctrl_wr_s[c] & bus.hid_wrdata[2];
        // A push into a full FIFO only survives when a pop frees the slot in the same cycle.
        assign mem_we_s[c]  = push_s[c] & ~flush_s[c] & (~full_s[c] | pop_s[c]);
        assign ovf_set_s[c] = push_s[c] & ~flush_s[c] & full_s[c] & ~pop_s[c];
    end

    // Per-channel pointer, count, overflow and interrupt-enable next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        ie_d     = ie_q;
        for (int c = 0; c < NCH; c++) begin
            if (flush_s[c]) begin
                wr_ptr_d[c] = PW'(0);
                rd_ptr_d[c] = PW'(0);
                count_d[c]  = CW'(0);
            end else begin
                if (mem_we_s[c]) begin
                    wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
                end else begin
                    wr_ptr_d[c] = wr_ptr_q[c];
                end
                if (pop_s[c]) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
                end else begin
                    rd_ptr_d[c] = rd_ptr_q[c];
                end
                if (mem_we_s[c] & ~pop_s[c]) begin
                    count_d[c] = count_q[c] + CW'(1);
                end else if (pop_s[c] & ~mem_we_s[c]) begin
                    count_d[c] = count_q[c] - CW'(1);
                end else begin
                    count_d[c] = count_q[c];
                end
            end
            // A fresh overflow outranks a clear arriving in the same cycle.
            if (ovf_set_s[c]) begin
                ovf_d[c] = 1'b1;
            end else if (ovf_clr_s[c]) begin
                ovf_d[c] = 1'b0;
            end else begin
                ovf_d[c] = ovf_q[c];
            end
            if (ctrl_wr_s[c]) begin
                ie_d[c] = bus.hid_wrdata[0];
            end else begin
                ie_d[c] = ie_q[c];
            end
        end
    end

    // Read-data mux; unmapped channels and the reserved register read as zero.
    always_comb begin
        rddata_d = rddata_q;
        if (bus_rd_s) begin
            rddata_d = 64'd0;
            for (int c = 0; c < NCH; c++) begin
                if (sel_s[c]) begin
                    case (reg_sel_s)
                        REG_DATA: begin
                            rddata_d[63]       = ~empty_s[c];
                            rddata_d[EW-1:0]   = empty_s[c] ? EW'(0) : head_s[c];
                        end
                        REG_STAT: begin
                            rddata_d[0]     = empty_s[c];
                            rddata_d[1]     = full_s[c];
                            rddata_d[2]     = ovf_q[c];
                            rddata_d[23:16] = 8'(count_q[c]);
                        end
                        REG_CTRL: begin
                            rddata_d[2:0] = {ovf_q[c], 1'b0, ie_q[c]};
                        end
                        default: begin
                            rddata_d = 64'd0;
                        end
                    endcase
                end else begin
                    rddata_d = rddata_d;
                end
            end
        end else begin
            rddata_d = rddata_q;
        end
    end

    // Interrupt level from the registered FIFO state.
    always_comb begin
        irq_d = |(ie_q & (~empty_s | ovf_q));
    end

    // Control and output registers.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            rdy_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            ie_q     <= '0;
            rddata_q <= 64'd0;
            irq_q    <= 1'b0;
        end else begin
            rdy_q    <= scan_ready_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ie_q     <= ie_d;
            rddata_q <= rddata_d;
            irq_q    <= irq_d;
        end
    end

    // Entry storage; contents are only observed through valid pointers.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NCH; c++) begin
            if (mem_we_s[c]) begin
                mem_q[c][wr_ptr_q[c]] <= entry_s[c];
            end
        end
    end

    assign bus.hid_rddata = rddata_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_hid_rx_fifo.sv
// Directed bench for hid_rx_fifo (NCH=2, DEPTH=16, CODE_W=8).
module tb_hid_rx_fifo;

    localparam int NCH    = 2;
    localparam int DEPTH  = 16;
    localparam int CODE_W = 8;
    localparam int R_DATA = 0;
    localparam int R_STAT = 1;
    localparam int R_CTRL = 2;
    localparam int R_RSVD = 3;

    logic                  clk_i = 1'b0;
    logic                  rst;
    logic [NCH-1:0]        scan_ready;
    logic [NCH*CODE_W-1:0] scan_code;
    logic [NCH-1:0]        scan_rel;
    logic                  irq_o;
    logic [63:0]           rd;

    int n_checks = 0;
    int n_fail   = 0;

    hid_rx_fifo_if bus ();

    hid_rx_fifo #(.NCH(NCH), .DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
        .clk_i           (clk_i),
        .rst             (rst),
        .scan_ready_i    (scan_ready),
        .scan_code_i     (scan_code),
        .scan_released_i (scan_rel),
        .bus             (bus),
        .irq_o           (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mk_addr(input int ch, input int r);
        return 20'((ch << 5) | (r << 3));
    endfunction

    task automatic bus_write(input int ch, input int r, input logic [63:0] d);
        @(negedge clk_i);
        bus.hid_en     = 1'b1;
        bus.hid_we     = 8'hFF;
        bus.hid_addr   = mk_addr(ch, r);
        bus.hid_wrdata = d;
        @(negedge clk_i);
        bus.hid_en     = 1'b0;
        bus.hid_we     = 8'h00;
    endtask

    task automatic bus_read(input int ch, input int r, output logic [63:0] d);
        @(negedge clk_i);
        bus.hid_en   = 1'b1;
        bus.hid_we   = 8'h00;
        bus.hid_addr = mk_addr(ch, r);
        @(negedge clk_i);
        bus.hid_en   = 1'b0;
        d = bus.hid_rddata;
    endtask

    task automatic push(input int ch, input logic [7:0] code, input logic rel);
        @(negedge clk_i);
        scan_ready[ch]          = 1'b1;
        scan_code[ch*8 +: 8]    = code;
        scan_rel[ch]            = rel;
        @(negedge clk_i);
        scan_ready[ch]          = 1'b0;
    endtask

    // Scan-code edge on one channel in the same cycle as a bus write.
    task automatic push_and_write(input int pch, input logic [7:0] code,
                                  input int wch, input int r, input logic [63:0] d);
        @(negedge clk_i);
        scan_ready[pch]       = 1'b1;
        scan_code[pch*8 +: 8] = code;
        scan_rel[pch]         = 1'b0;
        bus.hid_en            = 1'b1;
        bus.hid_we            = 8'hFF;
        bus.hid_addr          = mk_addr(wch, r);
        bus.hid_wrdata        = d;
        @(negedge clk_i);
        scan_ready[pch]       = 1'b0;
        bus.hid_en            = 1'b0;
        bus.hid_we            = 8'h00;
    endtask

    initial begin
        rst            = 1'b1;
        scan_ready     = '0;
        scan_code      = '0;
        scan_rel       = '0;
        bus.hid_en     = 1'b0;
        bus.hid_we     = 8'h00;
        bus.hid_addr   = 20'h0;
        bus.hid_wrdata = 64'h0;
        repeat (2) @(negedge clk_i);
        check_eq("reset rddata", bus.hid_rddata, 64'h0);
        check_eq("reset irq", {63'h0, irq_o}, 64'h0);
        rst = 1'b0;

        bus_read(0, R_STAT, rd);
        check_eq("c0 status idle", rd, 64'h1);

        // Basic push, peek, pop.
        push(0, 8'h1C, 1'b0);
        bus_read(0, R_DATA, rd);
        check_eq("c0 data 1C", rd, 64'h8000_0000_0000_001C);
        bus_write(0, R_DATA, 64'h0);
        bus_read(0, R_STAT, rd);
        check_eq("c0 status after pop", rd, 64'h1);

        push(0, 8'h55, 1'b1);
        bus_read(0, R_DATA, rd);
        check_eq("c0 data released", rd, 64'h8000_0000_0000_0155);
        bus_write(0, R_DATA, 64'h0);

        // Overflow on channel 1.
        for (int i = 0; i < 17; i++) push(1, 8'(i), 1'b0);
        bus_read(1, R_STAT, rd);
        check_eq("c1 status full ovf", rd, 64'h0000_0000_0010_0006);
        bus_read(0, R_STAT, rd);
        check_eq("c0 untouched", rd, 64'h1);
        for (int i = 0; i < 16; i++) begin
            bus_read(1, R_DATA, rd);
            check_eq($sformatf("c1 drain %0d", i), rd, 64'h8000_0000_0000_0000 | 64'(i));
            bus_write(1, R_DATA, 64'h0);
        end
        bus_read(1, R_STAT, rd);
        check_eq("c1 status empty ovf", rd, 64'h5);
        bus_read(1, R_CTRL, rd);
        check_eq("c1 ctrl ovf", rd, 64'h4);
        bus_write(1, R_CTRL, 64'h4);
        bus_read(1, R_STAT, rd);
        check_eq("c1 ovf cleared", rd, 64'h1);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 16; i++) push(1, 8'(8'h20 + i), 1'b0);
        push_and_write(1, 8'h30, 1, R_DATA, 64'h0);
        bus_read(1, R_STAT, rd);
        check_eq("c1 full push+pop", rd, 64'h0000_0000_0010_0002);
        bus_read(1, R_DATA, rd);
        check_eq("c1 head advanced", rd, 64'h8000_0000_0000_0021);
        bus_write(1, R_CTRL, 64'h2);
        bus_read(1, R_STAT, rd);
        check_eq("c1 flushed", rd, 64'h1);

        // Interrupt timing on channel 0.
        bus_write(0, R_CTRL, 64'h1);
        bus_read(0, R_CTRL, rd);
        check_eq("c0 ctrl ie", rd, 64'h1);
        check_eq("irq idle", {63'h0, irq_o}, 64'h0);
        @(negedge clk_i);
        scan_ready[0]  = 1'b1;
        scan_code[7:0] = 8'h33;
        @(negedge clk_i);
        check_eq("irq +1", {63'h0, irq_o}, 64'h0);
        scan_ready[0]  = 1'b0;
        @(negedge clk_i);
        check_eq("irq +2", {63'h0, irq_o}, 64'h1);
        bus_write(0, R_DATA, 64'h0);
        check_eq("irq at pop", {63'h0, irq_o}, 64'h1);
        @(negedge clk_i);
        check_eq("irq after pop", {63'h0, irq_o}, 64'h0);
        bus_write(0, R_CTRL, 64'h0);

        // Flush wins over a same-cycle push.
        for (int i = 0; i < 5; i++) push(1, 8'(8'h60 + i), 1'b0);
        push_and_write(1, 8'h99, 1, R_CTRL, 64'h2);
        bus_read(1, R_STAT, rd);
        check_eq("flush with push", rd, 64'h1);
        push(1, 8'h77, 1'b0);
        bus_read(1, R_DATA, rd);
        check_eq("after flush head", rd, 64'h8000_0000_0000_0077);
        bus_write(1, R_CTRL, 64'h2);

        // Empty FIFO: push and pop together, then a lone pop.
        push_and_write(0, 8'h5A, 0, R_DATA, 64'h0);
        bus_read(0, R_STAT, rd);
        check_eq("empty push+pop", rd, 64'h0000_0000_0001_0000);
        bus_read(0, R_DATA, rd);
        check_eq("empty push+pop data", rd, 64'h8000_0000_0000_005A);
        bus_write(0, R_DATA, 64'h0);
        bus_write(0, R_DATA, 64'h0);
        bus_read(0, R_STAT, rd);
        check_eq("empty pop ignored", rd, 64'h1);
        bus_write(0, R_CTRL, 64'h0);
        check_eq("write keeps rddata", bus.hid_rddata, 64'h1);

        bus_read(5, R_STAT, rd);
        check_eq("unmapped channel", rd, 64'h0);
        bus_read(0, R_RSVD, rd);
        check_eq("reserved reg", rd, 64'h0);

        // Asynchronous reset with entries queued and the strobe held.
        bus_write(0, R_CTRL, 64'h1);
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        @(negedge clk_i);
        scan_ready[0]  = 1'b1;
        scan_code[7:0] = 8'h43;
        @(negedge clk_i);
        bus_read(0, R_STAT, rd);
        check_eq("pre-reset count", rd, 64'h0000_0000_0003_0000);
        bus_read(0, R_DATA, rd);
        check_eq("pre-reset head", rd, 64'h8000_0000_0000_0041);
        check_eq("pre-reset irq", {63'h0, irq_o}, 64'h1);
        #2 rst = 1'b1;
        #1;
        check_eq("async reset rddata", bus.hid_rddata, 64'h0);
        check_eq("async reset irq", {63'h0, irq_o}, 64'h0);
        @(negedge clk_i);
        scan_code[7:0] = 8'h45;
        @(negedge clk_i);
        rst = 1'b0;
        repeat (3) @(negedge clk_i);
        scan_ready[0] = 1'b0;
        bus_read(0, R_STAT, rd);
        check_eq("post-reset one push", rd, 64'h0000_0000_0001_0000);
        bus_read(0, R_DATA, rd);
        check_eq("post-reset data", rd, 64'h8000_0000_0000_0045);
        check_eq("post-reset irq off", {63'h0, irq_o}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
